// File: rtl/aes256_ctr_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes256_ctr_round_ctrl
//
// Sequencing controller for AES-256 counter-mode encryption around a single
// shared combinational round-operation datapath. Per block it forms the
// counter block, applies the initial AddRoundKey, walks the datapath through
// rounds 1..14, and XORs the resulting keystream with the captured plaintext.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   start, abort       job start (sampled in IDLE) / job cancel
//   iv, num_blocks     initial counter block and block count, latched on start
//   pt_data/valid/ready  plaintext input handshake (ready only in LOAD)
//   ct_data/valid/ready  ciphertext output handshake (registered, held stable)
//   rk_idx, rk         round-key index out, round key back in the same cycle
//   dp_state, dp_final, dp_out  state / last-round flag to the datapath, result back
//   busy, done         not-IDLE indicator, one-cycle job-complete pulse
// ---------------------------------------------------------------------------
module aes256_ctr_round_ctrl #(
    parameter int BLOCK_W = 128,
    parameter int CTR_W   = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [BLOCK_W-1:0] iv,
    input  logic [CNT_W-1:0]   num_blocks,
    input  logic [BLOCK_W-1:0] pt_data,
    input  logic               pt_valid,
    output logic               pt_ready,
    output logic [BLOCK_W-1:0] ct_data,
    output logic               ct_valid,
    input  logic               ct_ready,
    output logic [3:0]         rk_idx,
    input  logic [BLOCK_W-1:0] rk,
    output logic [BLOCK_W-1:0] dp_state,
    output logic               dp_final,
    input  logic [BLOCK_W-1:0] dp_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, OUT} state_t;

    localparam logic [3:0] LAST_RK = 4'd14;

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] ctr_q, ctr_d;
    logic [CNT_W-1:0]   left_q, left_d;
    logic [BLOCK_W-1:0] pt_q, pt_d;
    logic [BLOCK_W-1:0] dp_state_q, dp_state_d;
    logic [3:0]         rk_idx_q, rk_idx_d;
    logic [BLOCK_W-1:0] ct_data_q, ct_data_d;
    logic               ct_valid_q, ct_valid_d;
    logic               pt_ready_q, pt_ready_d;
    logic               busy_q, busy_d;
    logic               dp_final_q, dp_final_d;
    logic               done_q, done_d;

    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        left_d     = left_q;
        pt_d       = pt_q;
        dp_state_d = dp_state_q;
        rk_idx_d   = rk_idx_q;
        ct_data_d  = ct_data_q;
        ct_valid_d = ct_valid_q;
        done_d     = 1'b0;

        if (abort && (state_q != IDLE)) begin
            // Abort beats every handshake in the same cycle: nothing is
            // captured, the counter does not advance and no done is raised.
            state_d    = IDLE;
            ct_valid_d = 1'b0;
            rk_idx_d   = 4'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        ctr_d  = iv;
                        left_d = num_blocks;
                        if (num_blocks == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
                LOAD: begin
                    rk_idx_d = 4'd0;
                    if (pt_valid) begin
                        pt_d       = pt_data;
                        dp_state_d = ctr_q ^ rk;   // initial AddRoundKey
                        rk_idx_d   = 4'd1;
                        state_d    = ROUND;
                    end
                end
                ROUND: begin
                    dp_state_d = dp_out;
                    if (rk_idx_q == LAST_RK) begin
                        ct_data_d  = dp_out ^ pt_q;
                        ct_valid_d = 1'b1;
                        rk_idx_d   = 4'd0;
                        state_d    = OUT;
                    end else begin
                        rk_idx_d = rk_idx_q + 4'd1;
                    end
                end
                OUT: begin
                    if (ct_ready) begin
                        ct_valid_d = 1'b0;
                        left_d     = left_q - CNT_W'(1);
                        // Only the low field counts; no carry into the upper bits.
                        ctr_d = {ctr_q[BLOCK_W-1:CTR_W], ctr_q[CTR_W-1:0] + CTR_W'(1)};
                        if (left_q == CNT_W'(1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Status outputs are registered off the next state so they line up
        // with state_q in the cycle they describe.
        pt_ready_d = (state_d == LOAD);
        busy_d     = (state_d != IDLE);
        dp_final_d = (rk_idx_d == LAST_RK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ctr_q      <= '0;
            left_q     <= '0;
            pt_q       <= '0;
            dp_state_q <= '0;
            rk_idx_q   <= 4'd0;
            ct_data_q  <= '0;
            ct_valid_q <= 1'b0;
            pt_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            dp_final_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            left_q     <= left_d;
            pt_q       <= pt_d;
            dp_state_q <= dp_state_d;
            rk_idx_q   <= rk_idx_d;
            ct_data_q  <= ct_data_d;
            ct_valid_q <= ct_valid_d;
            pt_ready_q <= pt_ready_d;
            busy_q     <= busy_d;
            dp_final_q <= dp_final_d;
            done_q     <= done_d;
        end
    end

    assign pt_ready = pt_ready_q;
    assign ct_data  = ct_data_q;
    assign ct_valid = ct_valid_q;
    assign rk_idx   = rk_idx_q;
    assign dp_state = dp_state_q;
    assign dp_final = dp_final_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes256_ctr_round_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for aes256_ctr_round_ctrl. The key schedule and round datapath are
// stand-in functions (a keyed mixing round with a distinct final round), so
// the controller's sequencing, counter handling and handshakes are checked
// against an independent per-block reference.
// ---------------------------------------------------------------------------
module tb_aes256_ctr_round_ctrl;

    logic         clk = 1'b0;
    logic         rst, start, abort;
    logic [127:0] iv, pt_data, ct_data, rk, dp_state, dp_out;
    logic [15:0]  num_blocks;
    logic         pt_valid, pt_ready, ct_valid, ct_ready, dp_final, busy, done;
    logic [3:0]   rk_idx;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] KEY_BASE = 128'h000102030405060708090a0b0c0d0e0f;

    aes256_ctr_round_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .iv(iv),
        .num_blocks(num_blocks), .pt_data(pt_data), .pt_valid(pt_valid),
        .pt_ready(pt_ready), .ct_data(ct_data), .ct_valid(ct_valid),
        .ct_ready(ct_ready), .rk_idx(rk_idx), .rk(rk), .dp_state(dp_state),
        .dp_final(dp_final), .dp_out(dp_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] rk_of(input logic [3:0] i);
        return KEY_BASE ^ {32{i}} ^ {8{4'(i + 4'd3), i, 8'h5a}};
    endfunction

    function automatic logic [127:0] round_f(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
        logic [127:0] r;
        r = {s[114:0], s[127:115]};
        if (!fin) r = (r + {s[63:0], s[127:64]}) ^ (s >> 7);
        return r ^ k;
    endfunction

    assign rk     = rk_of(rk_idx);
    assign dp_out = round_f(dp_state, rk, dp_final);

    function automatic logic [127:0] model(input logic [127:0] ctr, input logic [127:0] pt);
        logic [127:0] s;
        s = ctr ^ rk_of(4'd0);
        for (int i = 1; i <= 14; i++) s = round_f(s, rk_of(4'(i)), i == 14);
        return s ^ pt;
    endfunction

    function automatic logic [127:0] ctr_of(input logic [127:0] base, input int b);
        logic [31:0] lo;
        lo = base[31:0] + 32'(b);
        return {base[127:32], lo};
    endfunction

    function automatic logic [127:0] pt_of(input int seed, input int b);
        logic [31:0] w;
        if (seed == 0) return '0;
        w = 32'((seed << 16) | b) * 32'h9E3779B1;
        return {w, ~w, w ^ 32'h1234_5678, w + 32'd7};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    // Runs a full job; expected ciphertexts are queued up front and popped
    // as each ciphertext is presented.
    task automatic run_job(input logic [127:0] iv_i, input int n, input int seed,
                           input int bp_blk, input int bp_cyc, input bit poke_start);
        int           t_prev;
        int           k;
        logic [127:0] hold;
        for (int b = 0; b < n; b++) exp_q.push_back(model(ctr_of(iv_i, b), pt_of(seed, b)));
        iv = iv_i; num_blocks = 16'(n); start = 1'b1;
        pt_valid = 1'b1; ct_ready = 1'b1; pt_data = pt_of(seed, 0);
        tick();
        start = 1'b0;
        chk1("busy_after_start", busy, 1'b1);
        t_prev = -1;
        for (int b = 0; b < n; b++) begin
            pt_data = pt_of(seed, b);
            k = 0;
            while (!pt_ready && k < 40) begin tick(); k++; end
            chk1("pt_ready_load", pt_ready, 1'b1);
            chk("rk_idx_load", 128'(rk_idx), 128'(0));
            tick();
            chk("ctr_block", dp_state, ctr_of(iv_i, b) ^ rk_of(4'd0));
            for (int i = 1; i <= 14; i++) begin
                chk("rk_idx_seq", 128'(rk_idx), 128'(i));
                chk1("dp_final", dp_final, i == 14);
                chk1("pt_ready_round", pt_ready, 1'b0);
                if (poke_start && i == 5) begin
                    start = 1'b1; iv = ~iv_i; num_blocks = 16'd0;
                end else begin
                    start = 1'b0;
                end
                tick();
            end
            start = 1'b0;
            chk1("ct_valid_out", ct_valid, 1'b1);
            if (t_prev >= 0 && bp_blk != b - 1) chk("ct_spacing", 128'(cyc - t_prev), 128'(16));
            t_prev = cyc;
            if (exp_q.size() > 0) chk("ct_data", ct_data, exp_q.pop_front());
            else chk("scoreboard_empty", 128'(0), 128'(1));
            if (b == bp_blk) begin
                ct_ready = 1'b0;
                hold = ct_data;
                for (int c = 0; c < bp_cyc; c++) begin
                    tick();
                    chk1("bp_ct_valid", ct_valid, 1'b1);
                    chk("bp_ct_stable", ct_data, hold);
                    chk1("bp_pt_ready", pt_ready, 1'b0);
                end
                ct_ready = 1'b1;
            end
            tick();
            chk1("ct_valid_drop", ct_valid, 1'b0);
            if (b == n - 1) begin
                chk1("done_pulse", done, 1'b1);
                chk1("busy_end", busy, 1'b0);
                tick();
                chk1("done_clear", done, 1'b0);
            end else begin
                chk1("no_done_mid", done, 1'b0);
            end
        end
        pt_valid = 1'b0;
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; abort = 1'b0; iv = '0; num_blocks = '0;
        pt_data = '0; pt_valid = 1'b0; ct_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk1("rst_ct_valid", ct_valid, 1'b0);
        chk("rst_ct_data", ct_data, '0);
        chk1("rst_pt_ready", pt_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk("rst_rk_idx", 128'(rk_idx), 128'(0));
        chk1("rst_dp_final", dp_final, 1'b0);
        chk("rst_dp_state", dp_state, '0);

        // Single block, zero plaintext.
        run_job(128'h000102030405060708090a0b0c0d0e0f, 1, 0, -1, 0, 1'b0);
        // Four back-to-back blocks, with a start pulse while busy.
        run_job(128'h0011223344556677_8899aabb_00000010, 4, 1, -1, 0, 1'b1);
        // Backpressure on the middle block.
        run_job(128'hdeadbeef_cafef00d_01234567_00000100, 3, 2, 1, 5, 1'b0);
        // Low-field wrap, upper field untouched.
        run_job({96'hA5A5A5A5_A5A5A5A5_A5A5A5A5, 32'hFFFFFFFE}, 3, 3, -1, 0, 1'b0);

        // Zero-block job.
        iv = 128'h1; num_blocks = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk1("zero_done", done, 1'b1);
        chk1("zero_busy", busy, 1'b0);
        chk1("zero_pt_ready", pt_ready, 1'b0);
        tick();
        chk1("zero_done_clear", done, 1'b0);
        chk1("zero_pt_ready2", pt_ready, 1'b0);

        // Abort mid-round.
        iv = 128'h77; num_blocks = 16'd2; start = 1'b1; pt_valid = 1'b1; pt_data = 128'h5;
        ct_ready = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (rk_idx != 4'd7 && k < 40) begin tick(); k++; end
        chk("abort_reach_rk7", 128'(rk_idx), 128'(7));
        abort = 1'b1;
        tick();
        abort = 1'b0; pt_valid = 1'b0;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_ct_valid", ct_valid, 1'b0);
        chk("abort_rk_idx", 128'(rk_idx), 128'(0));
        chk1("abort_done", done, 1'b0);
        tick();
        chk1("abort_done2", done, 1'b0);
        chk1("abort_pt_ready", pt_ready, 1'b0);
        run_job(128'h0f0e0d0c_0b0a0908_07060504_03020100, 2, 4, -1, 0, 1'b0);

        // Reset while holding a ciphertext.
        iv = 128'h99; num_blocks = 16'd2; start = 1'b1; pt_valid = 1'b1; pt_data = 128'h3;
        ct_ready = 1'b0;
        tick();
        start = 1'b0;
        k = 0;
        while (!ct_valid && k < 40) begin tick(); k++; end
        chk1("rst_reach_out", ct_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0; pt_valid = 1'b0;
        chk1("rstout_ct_valid", ct_valid, 1'b0);
        chk("rstout_ct_data", ct_data, '0);
        chk1("rstout_busy", busy, 1'b0);
        chk1("rstout_done", done, 1'b0);
        chk("rstout_dp_state", dp_state, '0);
        tick();
        chk1("rstout_done2", done, 1'b0);
        run_job(128'hfedcba98_76543210_00000000_7fffffff, 2, 5, 0, 3, 1'b0);

        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/aes256_ctr_round_ctrl.md
Name: aes256_ctr_round_ctrl

Overview:
Sequencing controller for AES-256 counter-mode encryption built on one shared combinational round-operation datapath. For each block it generates the counter block, applies the initial AddRoundKey, and iterates the datapath through rounds 1..14, stepping the round-key index each cycle. It then XORs the keystream with the captured plaintext and returns ciphertext over a valid/ready handshake. It sits between the CTR stream front-end and the round-op/key-schedule datapath.

Parameters:
BLOCK_W, 128, data/state/key width per block
CTR_W, 32, width of the incrementing low field of the counter block
CNT_W, 16, width of the block-count input

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
start  input  1  begin a job; sampled only in IDLE
abort  input  1  synchronous job cancel
iv  input  BLOCK_W  initial counter block, latched on start
num_blocks  input  CNT_W  number of blocks in job, latched on start
pt_data  input  BLOCK_W  plaintext block
pt_valid  input  1  plaintext valid
pt_ready  output  1  plaintext accept
ct_data  output  BLOCK_W  ciphertext block (registered)
ct_valid  output  1  ciphertext valid
ct_ready  input  1  ciphertext accept
rk_idx  output  4  round-key index to key schedule (0..14)
rk  input  BLOCK_W  round key for rk_idx, same cycle (combinational lookup)
dp_state  output  BLOCK_W  state register driven to round-op datapath
dp_final  output  1  high when rk_idx==14 (datapath omits MixColumns)
dp_out  input  BLOCK_W  datapath result for (dp_state, rk, dp_final)
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after the last block is accepted downstream

Behaviour:
- Reset (rst=1 at posedge): state IDLE. ct_valid=0, ct_data=0, pt_ready=0, done=0, busy=0, rk_idx=0, dp_final=0, dp_state=0. Counter, block count and latched plaintext are cleared. Reset mid-job discards the job silently; no done pulse.
- FSM states: IDLE, LOAD, ROUND, OUT.
- IDLE: on start=1, latch ctr<=iv and left<=num_blocks. If num_blocks==0, pulse done next cycle and stay in IDLE. Otherwise go to LOAD.
- LOAD: pt_ready=1 and rk_idx=0. On pt_valid&&pt_ready: pt_reg<=pt_data, dp_state<=ctr^rk, rk_idx<=1, go to ROUND.
- ROUND: each cycle dp_state<=dp_out and rk_idx<=rk_idx+1. dp_final=1 only when rk_idx==14. In the rk_idx==14 cycle: ct_data<=dp_out^pt_reg, ct_valid<=1, rk_idx<=0, go to OUT.
- OUT: ct_valid and ct_data are held stable until ct_ready. On acceptance: ct_valid<=0, left<=left-1, and ctr low CTR_W bits<=low+1 mod 2^CTR_W (upper BLOCK_W-CTR_W bits unchanged, no carry into them). If left==1, go to IDLE and pulse done. Otherwise go to LOAD.
- Latency: pt accepted at cycle T gives ct_valid=1 at T+15. Minimum per-block period is 16 cycles (LOAD, 14 ROUND, 1 OUT with ct_ready=1).
- pt_ready is 0 outside LOAD. The controller never accepts a new plaintext while ct_valid=1.
- start is ignored while busy=1.
- abort=1 in any non-IDLE state: next state IDLE, ct_valid<=0, rk_idx<=0, no done. abort has priority over every handshake in the same cycle. rst has priority over abort.
- Counter wrap: low field 0xFFFFFFFF increments to 0x00000000; upper 96 bits are untouched.
- num_blocks = 2^CNT_W-1 is legal; left is decremented without underflow.

Test Plan:
- Single block, FIPS-197 AES-256 key, iv=0x000102..0F, num_blocks=1, pt=0: ct_data equals the AES-256 encryption of iv at T+15; rk_idx sequences 0,1..14; dp_final high only at 14; done pulses one cycle after ct handshake; busy falls with done.
- Four blocks with ct_ready and pt_valid tied high: 4 ciphertexts at 16-cycle spacing; counter low field iv+0..iv+3; each ct equals a reference model's output.
- Backpressure: ct_ready low for 5 cycles in OUT: ct_valid and ct_data stable, pt_ready=0, counter not incremented; on release the next block proceeds normally.
- Wrap: iv low field 0xFFFFFFFE, upper field 0xA5..A5, num_blocks=3: counter blocks end ...FFFE, ...FFFF, ...0000; upper 96 bits stay constant.
- num_blocks=0 with start: done pulses one cycle later, pt_ready never asserted, busy stays 0. A start pulse while busy is ignored.
- abort at rk_idx=7, and separately rst in OUT: controller returns to IDLE next cycle with ct_valid=0 and no done; a following start runs a clean job with correct output.
